grid_access_arbiter: RTL and testbench

//  Shares the single-port placement grid RAM (memoryRAM, N*N cells, EMPTY=-1 marks a free cell) between NREQ engines.

---
 rtl/grid_access_arbiter_pkg.sv | 23 ++
 rtl/grid_access_arbiter_rr_pick.sv | 32 +++
 rtl/grid_access_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_grid_access_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_access_arbiter_pkg.sv
// Shared definitions for the placement-grid access arbiter: data width,
// free-cell marker, request op codes and controller state encodings.
package grid_access_arbiter_pkg;

    localparam int DATA_W = 32;

    // A cell holding this value is free and may be claimed.
    localparam logic signed [DATA_W-1:0] EMPTY = -1;

    localparam logic [1:0] OP_RD    = 2'b00;
    localparam logic [1:0] OP_WR    = 2'b01;
    localparam logic [1:0] OP_CLAIM = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/grid_access_arbiter_rr_pick.sv
// Combinational round-robin pick: the first active requester at or after
// the pointer (wrapping) wins.
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // scan upward from the pointer and keep the first requester seen
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NREQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/grid_access_arbiter.sv
// Arbitrates the single-port placement grid RAM between NREQ engines and
// performs read, write and atomic claim (test-and-set on EMPTY) on (x,y).
module grid_access_arbiter
    import grid_access_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int N       = 6,
    parameter int ADDR_W  = 6,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [2*NREQ-1:0]        op,
    input  logic [DATA_W*NREQ-1:0]   x,
    input  logic [DATA_W*NREQ-1:0]   y,
    input  logic [DATA_W*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     claim_ok,
    output logic                     oob,
    output logic                     busy,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_din,
    input  logic [DATA_W-1:0]        mem_dout
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = 8;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [IDX_W-1:0]          id_q, id_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [1:0]                op_q, op_d;
    logic signed [DATA_W-1:0]  x_q, x_d, y_q, y_d;
    logic [DATA_W-1:0]         wd_q, wd_d, rd_q, rd_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;

    logic [NREQ-1:0]           gnt_d, done_d;
    logic [DATA_W-1:0]         rdata_d, mem_din_d;
    logic                      claim_ok_d, oob_d, busy_d, mem_read_d, mem_write_d;
    logic [ADDR_W-1:0]         mem_addr_d;

    logic [NREQ-1:0]           pick_grant;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_any;
    logic [1:0]                sel_op;
    logic signed [DATA_W-1:0]  sel_x, sel_y;
    logic [DATA_W-1:0]         sel_wd;
    logic [NREQ-1:0]           id_onehot;

    function automatic logic in_range(input logic signed [DATA_W-1:0] v);
        return (v >= 0) && (v < N);
    endfunction

    rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // route the winning requester's operands to the latch inputs
    always_comb begin
        sel_op = OP_RD;
        sel_x  = '0;
        sel_y  = '0;
        sel_wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_op = op[2*i +: 2];
                sel_x  = x[DATA_W*i +: DATA_W];
                sel_y  = y[DATA_W*i +: DATA_W];
                sel_wd = wdata[DATA_W*i +: DATA_W];
            end
        end
        id_onehot        = '0;
        id_onehot[id_q]  = 1'b1;
    end

    // next state and next registered outputs; strobes and pulses default low
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        wd_d        = wd_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        gnt_d       = '0;
        done_d      = '0;
        rdata_d     = rdata;
        claim_ok_d  = claim_ok;
        oob_d       = oob;
        busy_d      = busy;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr;
        mem_din_d   = mem_din;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    id_d    = pick_idx;
                    op_d    = sel_op;
                    x_d     = sel_x;
                    y_d     = sel_y;
                    wd_d    = sel_wd;
                    addr_d  = ADDR_W'(sel_x * N + sel_y);
                    rd_d    = '0;
                    gnt_d   = pick_grant;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!(in_range(x_q) && in_range(y_q))) begin
                    done_d     = id_onehot;
                    rdata_d    = '0;
                    claim_ok_d = 1'b0;
                    oob_d      = 1'b1;
                    state_d    = ST_DONE;
                end else if (op_q == OP_WR) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_din_d   = wd_q;
                    state_d     = ST_WRITE;
                end else begin
                    // plain reads, claims and the reserved op all start with a read
                    mem_read_d = 1'b1;
                    mem_addr_d = addr_q;
                    cnt_d      = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                rd_d = mem_dout;
                if (op_q == OP_CLAIM && mem_dout == EMPTY) begin
                    // still holding the RAM, so read-then-write is atomic
                    mem_write_d = 1'b1;
                    mem_din_d   = wd_q;
                    state_d     = ST_WRITE;
                end else begin
                    done_d     = id_onehot;
                    rdata_d    = mem_dout;
                    claim_ok_d = 1'b0;
                    oob_d      = 1'b0;
                    state_d    = ST_DONE;
                end
            end
            ST_WRITE: begin
                done_d     = id_onehot;
                rdata_d    = rd_q;
                claim_ok_d = (op_q == OP_CLAIM);
                oob_d      = 1'b0;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                ptr_d   = IDX_W'((int'(id_q) + 1) % NREQ);
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state, pointer and all outputs; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            claim_ok  <= 1'b0;
            oob       <= 1'b0;
            busy      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            gnt       <= gnt_d;
            done      <= done_d;
            rdata     <= rdata_d;
            claim_ok  <= claim_ok_d;
            oob       <= oob_d;
            busy      <= busy_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            mem_addr  <= mem_addr_d;
            mem_din   <= mem_din_d;
        end
    end

    // latched request operands and captured read data (qualified by state)
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        x_q    <= x_d;
        y_q    <= y_d;
        wd_q   <= wd_d;
        rd_q   <= rd_d;
        addr_q <= addr_d;
    end

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Bench for grid_access_arbiter: vector table plus hand-written sequences,
// with an in-order scoreboard checked whenever done pulses.
module tb_grid_access_arbiter;
    import grid_access_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam logic [31:0] EMP = 32'hFFFF_FFFF;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  op;
    logic [32*NREQ-1:0] x, y, wdata;
    logic [NREQ-1:0]    gnt, done;
    logic [31:0]        rdata, mem_din, mem_dout;
    logic               claim_ok, oob, busy, mem_read, mem_write;
    logic [5:0]         mem_addr;
    logic               preload;
    logic [31:0]        ram [0:63];

    typedef struct {
        int          id;
        bit          chk_rdata;
        logic [31:0] rdata;
        bit          claim_ok;
        bit          oob;
        int          lat;
    } exp_t;

    typedef struct {
        int          r;
        logic [1:0]  op;
        int          x;
        int          y;
        logic [31:0] wd;
        logic [31:0] rdata;
        bit          chk_rdata;
        bit          claim_ok;
        bit          oob;
        int          lat;
        int          n_rd;
        int          n_wr;
        int          wa;
    } vec_t;

    exp_t  sb[$];
    vec_t  vec [13];
    int    checks = 0, errors = 0;
    int    cyc = 0, gnt_cyc = 0;
    int    rd_count = 0, wr_count = 0, last_wr_addr = 0;
    logic [31:0] last_wr_data = '0;
    string cur = "init";

    grid_access_arbiter #(.NREQ(NREQ), .N(6), .ADDR_W(6), .MEM_LAT(1)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .x(x), .y(y), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .claim_ok(claim_ok), .oob(oob),
        .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // grid RAM model with one edge of read latency
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram[i] <= EMP;
            ram[15]  <= 32'd7;
            mem_dout <= '0;
        end else begin
            if (mem_write) ram[mem_addr] <= mem_din;
            if (mem_read)  mem_dout <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s:%s actual=%0h required=%0h", cur, nm, act, exp);
        end
    endtask

    // advance to the next falling edge and observe the DUT there
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (mem_write) begin
            wr_count++;
            last_wr_addr = int'(mem_addr);
            last_wr_data = mem_din;
        end
        if (mem_read) rd_count++;
        if (gnt != 0) begin
            gnt_cyc = cyc;
            chk("gnt_onehot", 64'($onehot0(gnt)), 1);
        end
        if (gnt != 0 || done != 0)
            chk("gnt_done_apart", 64'((gnt != 0) && (done != 0)), 0);
        if (done != 0) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                e = sb.pop_front();
                chk("done_id", done, 2'b01 << e.id);
                chk("latency", cyc - gnt_cyc, e.lat);
                chk("oob", oob, e.oob);
                chk("claim_ok", claim_ok, e.claim_ok);
                if (e.chk_rdata) chk("rdata", rdata, e.rdata);
            end
        end
    endtask

    task automatic drive(input int r, input logic [1:0] o, input int vx, input int vy,
                         input logic [31:0] vwd);
        op[2*r +: 2]     = o;
        x[32*r +: 32]    = vx;
        y[32*r +: 32]    = vy;
        wdata[32*r +: 32] = vwd;
        req = req | (2'b01 << r);
    endtask

    task automatic wait_gnt(input int r);
        bit ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (((gnt >> r) & 2'b01) != 0) begin
                ok = 1'b1;
                break;
            end
        end
        req = req & ~(2'b01 << r);
        chk("gnt_seen", 64'(ok), 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_reached", 64'(ok), 1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int rd0, wr0;
        cur = nm;
        rd0 = rd_count;
        wr0 = wr_count;
        sb.push_back('{v.r, v.chk_rdata, v.rdata, v.claim_ok, v.oob, v.lat});
        drive(v.r, v.op, v.x, v.y, v.wd);
        wait_gnt(v.r);
        wait_idle();
        chk("mem_reads", rd_count - rd0, v.n_rd);
        chk("mem_writes", wr_count - wr0, v.n_wr);
        if (v.n_wr != 0) begin
            chk("wr_addr", last_wr_addr, v.wa);
            chk("wr_data", last_wr_data, v.wd);
        end
    endtask

    initial begin
        logic [NREQ-1:0] order [4];
        logic [NREQ-1:0] first;
        int n, wr0;

        //          r  op        x   y  wd      rdata  chkrd ok oob lat rd wr wa
        vec[0]  = '{0, OP_RD,    2,  3, 32'd0,  32'd7,  1, 0, 0, 3, 1, 0, 0};
        vec[1]  = '{0, OP_CLAIM, 1,  1, 32'd4,  EMP,    1, 1, 0, 4, 1, 1, 7};
        vec[2]  = '{1, OP_CLAIM, 1,  1, 32'd5,  32'd4,  1, 0, 0, 3, 1, 0, 0};
        vec[3]  = '{1, OP_CLAIM, 6,  0, 32'd8,  32'd0,  0, 0, 1, 1, 0, 0, 0};
        vec[4]  = '{1, OP_CLAIM, -1, 2, 32'd8,  32'd0,  0, 0, 1, 1, 0, 0, 0};
        vec[5]  = '{0, OP_WR,    0,  5, 32'd11, 32'd0,  0, 0, 0, 2, 0, 1, 5};
        vec[6]  = '{1, OP_RD,    0,  5, 32'd0,  32'd11, 1, 0, 0, 3, 1, 0, 0};
        vec[7]  = '{0, 2'b11,    2,  3, 32'd0,  32'd7,  1, 0, 0, 3, 1, 0, 0};
        vec[8]  = '{1, OP_CLAIM, 0,  5, 32'd3,  32'd11, 1, 0, 0, 3, 1, 0, 0};
        vec[9]  = '{0, OP_RD,    5,  0, 32'd0,  EMP,    1, 0, 0, 3, 1, 0, 0};
        vec[10] = '{0, OP_WR,    0,  6, 32'd1,  32'd0,  0, 0, 1, 1, 0, 0, 0};
        vec[11] = '{1, OP_RD,    2, -1, 32'd0,  32'd0,  0, 0, 1, 1, 0, 0, 0};
        vec[12] = '{0, OP_CLAIM, 5,  5, 32'hAB, EMP,    1, 1, 0, 4, 1, 1, 35};

        reset = 1'b1; preload = 1'b1;
        req = '0; op = '0; x = '0; y = '0; wdata = '0;
        tick();
        preload = 1'b0;
        tick();
        tick();
        cur = "reset";
        chk("ctrl_zero", {gnt, done, busy, mem_read, mem_write, claim_ok, oob}, 0);
        chk("rdata_zero", rdata, 0);
        chk("mem_bus_zero", {mem_addr, mem_din}, 0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vec[i], $sformatf("vec%0d", i));

        // both requesters held from reset: grants must alternate 0,1,0,1
        cur = "rotation";
        reset = 1'b1;
        tick();
        op = '0;
        x = {32'd2, 32'd2};
        y = {32'd3, 32'd3};
        for (int i = 0; i < 4; i++) sb.push_back('{i % 2, 1'b1, 32'd7, 1'b0, 1'b0, 3});
        req = 2'b11;
        tick();
        reset = 1'b0;
        n = 0;
        for (int k = 0; k < 100 && n < 4; k++) begin
            tick();
            if (gnt != 0) begin
                order[n] = gnt;
                n++;
                if (n == 4) req = '0;
            end
        end
        chk("grant_count", n, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("order%0d", i), order[i], 2'b01 << (i % 2));
        wait_idle();

        // reset during a claim's wait aborts it before the write
        cur = "reset_mid";
        wr0 = wr_count;
        drive(0, OP_CLAIM, 4, 4, 32'd6);
        wait_gnt(0);
        tick();
        chk("in_wait_read", mem_read, 1);
        reset = 1'b1;
        tick();
        chk("ctrl_zero", {gnt, done, busy, mem_read, mem_write, claim_ok, oob}, 0);
        chk("rdata_zero", rdata, 0);
        chk("mem_bus_zero", {mem_addr, mem_din}, 0);
        reset = 1'b0;
        repeat (8) tick();
        chk("no_write", wr_count - wr0, 0);
        run_vec('{0, OP_RD, 4, 4, 32'd0, EMP, 1, 0, 0, 3, 1, 0, 0}, "reset_mid_readback");

        // simultaneous write (req0) and read (req1) of the same cell
        cur = "wr_then_rd";
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        wr0 = wr_count;
        sb.push_back('{0, 1'b0, 32'd0, 1'b0, 1'b0, 2});
        sb.push_back('{1, 1'b1, 32'd9, 1'b0, 1'b0, 3});
        drive(0, OP_WR, 5, 5, 32'd9);
        drive(1, OP_RD, 5, 5, 32'd0);
        first = '0;
        n = 0;
        for (int k = 0; k < 60 && n < 2; k++) begin
            tick();
            if (gnt != 0) begin
                if (n == 0) first = gnt;
                n++;
                req = req & ~gnt;
            end
        end
        chk("grant_count", n, 2);
        chk("first_gnt", first, 2'b01);
        wait_idle();
        chk("mem_writes", wr_count - wr0, 1);
        chk("wr_addr", last_wr_addr, 35);
        chk("wr_data", last_wr_data, 32'd9);

        cur = "end";
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
